// File: rtl/data_memory_responder.sv
// Multi-cycle data memory slave for a pipelined CPU memory stage.
// Accepts one byte/half/word load or store in IDLE, holds the pipeline for LATENCY+1 cycles, then pulses DoneOut.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  SizeIn,
  input  logic        SignedIn,
  input  logic [31:0] AddressIn,
  input  logic [31:0] WriteDataIn,
  output logic [31:0] ReadDataOut,
  output logic        StallOut,
  output logic        DoneOut,
  output logic        ErrorOut
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  size_t           size_q, size_d;
  logic            signed_q, signed_d;
  logic            write_q, write_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH_WORDS];

  // Upper address bits are deliberately dropped so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^AddressIn[31:AW+2];

  // Request decode (only meaningful in IDLE)
  size_t req_size;
  logic  req_any, req_reject, req_valid, misaligned;

  always_comb begin
    case (SizeIn)
      2'b00:   req_size = SZ_BYTE;
      2'b01:   req_size = SZ_HALF;
      default: req_size = SZ_WORD;
    endcase
    misaligned = ((req_size == SZ_HALF) && AddressIn[0]) ||
                 ((req_size == SZ_WORD) && (AddressIn[1:0] != 2'b00));
    req_any    = MemReadIn | MemWriteIn;
    req_reject = req_any && ((MemReadIn && MemWriteIn) || misaligned);
    req_valid  = req_any && !req_reject;
  end

  // Datapath for the captured access
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word, load_ext, wlane;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [3:0]    wbe;

  assign word_idx = addr_q[AW+1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    rd_byte = rd_word[8*addr_q[1:0] +: 8];
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      SZ_BYTE: begin
        load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
        wbe      = 4'b0001 << addr_q[1:0];
        wlane    = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
        wbe      = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{wdata_q[15:0]}};
      end
      default: begin
        load_ext = rd_word;
        wbe      = 4'b1111;
        wlane    = wdata_q;
      end
    endcase
  end

  // Next-state and output logic
  logic stall, done, err, mem_we;

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    stall    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall    = 1'b1;
          addr_d   = AddressIn[AW+1:0];
          wdata_d  = WriteDataIn;
          size_d   = req_size;
          signed_d = SignedIn;
          write_d  = MemWriteIn;
          cnt_d    = CNT_LOAD;
          state_d  = BUSY;
        end else if (req_reject) begin
          err = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          if (write_q) mem_we = 1'b1;
          else         rdata_d = load_ext;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: request-driven outputs are combinational, so they are gated by reset to read 0 while it is held.
  assign StallOut    = stall & Rst_n;
  assign ErrorOut    = err & Rst_n;
  assign DoneOut     = done;
  assign ReadDataOut = rdata_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      rdata_q  <= rdata_d;
    end
  end

  // NOTE: the storage array has no reset; its contents survive Rst_n and it maps onto plain RAM.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder (DEPTH_WORDS=1024, LATENCY=2).
module tb_data_memory_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, sgn;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, done, err;

  int checks = 0;
  int errors = 0;

  data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .Clk(clk), .Rst_n(rst_n),
    .MemReadIn(mem_read), .MemWriteIn(mem_write),
    .SizeIn(size), .SignedIn(sgn),
    .AddressIn(addr), .WriteDataIn(wdata),
    .ReadDataOut(rdata), .StallOut(stall), .DoneOut(done), .ErrorOut(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    size      = 2'b00;
    sgn       = 1'b0;
    addr      = '0;
    wdata     = '0;
  endtask

  // One accepted access; exp_rd is the ReadDataOut value expected after DONE.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic scramble, input string tag);
    int stalls, done_at;
    @(negedge clk);
    mem_read = rd; mem_write = wr; size = sz; sgn = sg; addr = a; wdata = wd;
    #1;
    stalls  = 0;
    done_at = -1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (scramble && c == 1) begin
        addr  = a ^ 32'h4;
        wdata = ~wd;
      end
      if (stall) stalls++;
      if (done) begin done_at = c; break; end
    end
    drive_idle();
    check({tag, "_stall_cycles"}, stalls, LAT + 1);
    check({tag, "_done_cycle"}, done_at, LAT + 1);
    check({tag, "_rdata"}, rdata, exp_rd);
  endtask

  task automatic reject(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input string tag);
    @(negedge clk);
    mem_read = rd; mem_write = wr; size = sz; sgn = 1'b0; addr = a; wdata = 32'hFFFF_FFFF;
    #1;
    check({tag, "_err_stall"}, {30'd0, err, stall}, 32'h2);
    @(negedge clk);
    drive_idle();
    #1;
    check({tag, "_after"}, {29'd0, stall, done, err}, 32'h0);
  endtask

  initial begin
    drive_idle();
    rst_n    = 1'b0;
    mem_read = 1'b1;
    #1;
    check("reset_outputs", {28'd0, stall, done, err, 1'b0}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    #11;
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_outputs", {29'd0, stall, done, err}, 32'h0);

    // Word store/load, then byte lanes with sign/zero extension
    access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, "st_w10");
    access(1, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, "ld_w10");
    access(0, 1, 2'b00, 0, 32'h11, 32'h12345680, 32'hDEADBEEF, 0, "st_b11");
    access(1, 0, 2'b00, 1, 32'h11, 32'h0,        32'hFFFFFF80, 0, "ld_bs11");
    access(1, 0, 2'b00, 0, 32'h11, 32'h0,        32'h00000080, 0, "ld_bu11");
    access(1, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEAD80EF, 0, "ld_w10b");
    access(0, 1, 2'b01, 0, 32'h12, 32'h5555A5A5, 32'hDEAD80EF, 0, "st_h12");
    access(1, 0, 2'b01, 1, 32'h12, 32'h0,        32'hFFFFA5A5, 0, "ld_hs12");
    access(1, 0, 2'b01, 1, 32'h10, 32'h0,        32'hFFFF80EF, 0, "ld_hs10");
    access(1, 0, 2'b01, 0, 32'h10, 32'h0,        32'h000080EF, 0, "ld_hu10");

    // Rejected requests leave memory untouched
    reject(1, 0, 2'b01, 32'h13, "rej_half13");
    reject(1, 1, 2'b10, 32'h10, "rej_rdwr");
    reject(1, 0, 2'b10, 32'h12, "rej_word12");
    reject(0, 1, 2'b01, 32'h11, "rej_sthalf11");
    access(1, 0, 2'b11, 0, 32'h10, 32'h0,        32'hA5A580EF, 0, "ld_sz3_10");

    // Reset during BUSY discards the pending store
    access(0, 1, 2'b10, 0, 32'h20, 32'h11112222, 32'hA5A580EF, 0, "st_w20");
    @(negedge clk);
    mem_write = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678;
    @(negedge clk);
    drive_idle();
    #1;
    check("busy_before_reset", {31'd0, stall}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy_outputs", {29'd0, stall, done, err}, 32'h0);
    check("rst_busy_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 0, 2'b10, 0, 32'h20, 32'h0,        32'h11112222, 0, "ld_w20");

    // Address wrap and input changes during BUSY
    access(0, 1, 2'b10, 0, 32'h1000, 32'hCAFEF00D, 32'h11112222, 0, "st_w1000");
    access(1, 0, 2'b10, 0, 32'h0,    32'h0,        32'hCAFEF00D, 0, "ld_w0");
    access(0, 1, 2'b10, 0, 32'h34,   32'h01020304, 32'hCAFEF00D, 0, "st_w34");
    access(0, 1, 2'b10, 0, 32'h30,   32'h55AA33CC, 32'hCAFEF00D, 1, "st_w30_scr");
    access(1, 0, 2'b10, 0, 32'h30,   32'h0,        32'h55AA33CC, 0, "ld_w30");
    access(1, 0, 2'b10, 0, 32'h34,   32'h0,        32'h01020304, 1, "ld_w34_scr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
